safe_controller: RTL and testbench

//  Synchronous keypad door-safe core: encodes a 4x3 keypad into key codes, collects
//  a 6-digit entry, compares it with a stored password and runs the safe FSM.

---
 rtl/safe_pkg.sv | 30 +++
 rtl/keypad_bcd_encoder.sv | 30 +++
 rtl/safe_controller.sv | 154 +++++++++++++++
 tb/tb_safe_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared types and constants for the keypad safe: state encoding, key codes, entry length.
// Also holds the thermometer helper that drives the digit-count LEDs.
package safe_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_LOCKED = 3'd1,
      ST_OPEN   = 3'd2,
      ST_WRONG  = 3'd3,
      ST_SET    = 3'd4
   } state_t;

   localparam logic [3:0] KEY_STAR  = 4'hA;
   localparam logic [3:0] KEY_SHARP = 4'hB;
   localparam logic [3:0] KEY_NONE  = 4'hF;
   localparam int         PW_LEN    = 6;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   function automatic logic [PW_LEN-1:0] thermo(input logic [2:0] n);
      logic [PW_LEN-1:0] t;
      for (int i = 0; i < PW_LEN; i++) begin
         t[i] = (3'(i) < n);
      end
      return t;
   endfunction

endpackage

// File: rtl/keypad_bcd_encoder.sv
// Combinational 4x3 keypad decoder: exactly one row and one column give a key code, else KEY_NONE.
// Zero latency, no flow control.
module keypad_bcd_encoder
   import safe_pkg::*;
(
   input  logic [3:0] row_i,
   input  logic [2:0] col_i,
   output logic [3:0] code_o
);

   always_comb begin
      code_o = KEY_NONE;
      case ({row_i, col_i})
         7'b0001_001: code_o = 4'd1;
         7'b0001_010: code_o = 4'd2;
         7'b0001_100: code_o = 4'd3;
         7'b0010_001: code_o = 4'd4;
         7'b0010_010: code_o = 4'd5;
         7'b0010_100: code_o = 4'd6;
         7'b0100_001: code_o = 4'd7;
         7'b0100_010: code_o = 4'd8;
         7'b0100_100: code_o = 4'd9;
         7'b1000_001: code_o = KEY_STAR;
         7'b1000_010: code_o = 4'd0;
         7'b1000_100: code_o = KEY_SHARP;
         default:     code_o = KEY_NONE;
      endcase
   end

endmodule

// File: rtl/safe_controller.sv
// Keypad safe core: synchronizes pins, detects key presses, collects a 6-digit entry and runs the safe FSM.
// A press reaches state/password_led SYNC_STAGES+1 clock edges after the pins settle; no backpressure.
module safe_controller
   import safe_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          WRONG_HOLD  = 4,
   parameter logic [23:0] DEFAULT_PW  = 24'h123456
) (
   input  logic       clk,
   input  logic       initialize_n,
   input  logic       row1,
   input  logic       row2,
   input  logic       row3,
   input  logic       row4,
   input  logic       col1,
   input  logic       col2,
   input  logic       col3,
   input  logic       reset_password,
   output logic [5:0] password_led,
   output logic [2:0] state
);

   localparam int HOLD_W = (WRONG_HOLD > 1) ? $clog2(WRONG_HOLD) : 1;

   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  pins;
   logic [7:0]                  pins_s;
   logic [3:0]                  key_code;
   logic [3:0]                  key_prev_q;
   logic                        rp_prev_q;
   logic                        press;
   logic                        rp_rise;

   state_t                      state_q;
   logic [2:0]                  count_q;
   logic [23:0]                 entry_q;
   logic [23:0]                 pw_q;
   logic [HOLD_W-1:0]           hold_q;

   assign pins   = {reset_password, col3, col2, col1, row4, row3, row2, row1};
   assign pins_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge initialize_n) begin
      if (!initialize_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   keypad_bcd_encoder u_enc (
      .row_i  (pins_s[3:0]),
      .col_i  (pins_s[6:4]),
      .code_o (key_code)
   );

   // A press needs the previous code to be "no key": holds and direct key-to-key slides never fire.
   assign press   = (key_prev_q == KEY_NONE) && (key_code != KEY_NONE);
   assign rp_rise = pins_s[7] && !rp_prev_q;

   always_ff @(posedge clk or negedge initialize_n) begin
      if (!initialize_n) begin
         key_prev_q <= KEY_NONE;
         rp_prev_q  <= 1'b0;
      end else begin
         key_prev_q <= key_code;
         rp_prev_q  <= pins_s[7];
      end
   end

   always_ff @(posedge clk or negedge initialize_n) begin
      if (!initialize_n) begin
         state_q <= ST_OFF;
         count_q <= '0;
         entry_q <= '0;
         pw_q    <= DEFAULT_PW;
         hold_q  <= '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (press && key_code == KEY_SHARP) begin
                  state_q <= ST_LOCKED;
                  count_q <= '0;
                  entry_q <= '0;
               end
            end
            ST_LOCKED, ST_SET: begin
               if (press) begin
                  if (key_code == KEY_SHARP) begin
                     state_q <= ST_OFF;
                     count_q <= '0;
                     entry_q <= '0;
                  end else if (key_code == KEY_STAR) begin
                     count_q <= '0;
                     entry_q <= '0;
                     hold_q  <= '0;
                     if (state_q == ST_LOCKED) begin
                        state_q <= (count_q == 3'(PW_LEN) && entry_q == pw_q) ? ST_OPEN : ST_WRONG;
                     end else if (count_q == 3'(PW_LEN)) begin
                        pw_q    <= entry_q;
                        state_q <= ST_LOCKED;
                     end else begin
                        state_q <= ST_OPEN;
                     end
                  end else if (is_digit(key_code) && count_q < 3'(PW_LEN)) begin
                     // Shifting in MS-first leaves the first digit in the top nibble after six keys.
                     entry_q <= {entry_q[19:0], key_code};
                     count_q <= count_q + 3'd1;
                  end
               end
            end
            ST_OPEN: begin
               if (press) begin
                  if (key_code == KEY_SHARP) begin
                     state_q <= ST_OFF;
                  end else if (key_code == KEY_STAR) begin
                     state_q <= ST_LOCKED;
                  end
                  count_q <= '0;
                  entry_q <= '0;
               end else if (rp_rise) begin
                  state_q <= ST_SET;
                  count_q <= '0;
                  entry_q <= '0;
               end
            end
            ST_WRONG: begin
               if (press && key_code == KEY_SHARP) begin
                  state_q <= ST_OFF;
                  count_q <= '0;
                  entry_q <= '0;
               end else if (hold_q == HOLD_W'(WRONG_HOLD - 1)) begin
                  state_q <= ST_LOCKED;
               end else begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_q <= ST_OFF;
               count_q <= '0;
               entry_q <= '0;
            end
         endcase
      end
   end

   assign state        = state_q;
   assign password_led = (state_q == ST_LOCKED || state_q == ST_SET) ? thermo(count_q) : '0;

endmodule

// File: tb/tb_safe_controller.sv
// Scoreboard bench for safe_controller: stimulus queues expected state/LED changes with their cycle;
// a monitor pops one entry each time the outputs change.
module tb_safe_controller;

   typedef struct packed {
      logic [2:0]  st;
      logic [5:0]  led;
      int          at;
      logic [63:0] nm;
   } exp_t;

   logic       clk;
   logic       initialize_n;
   logic [3:0] row_v;
   logic [2:0] col_v;
   logic       reset_password;
   logic [5:0] password_led;
   logic [2:0] state;

   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];

   safe_controller dut (
      .clk            (clk),
      .initialize_n   (initialize_n),
      .row1           (row_v[0]),
      .row2           (row_v[1]),
      .row3           (row_v[2]),
      .row4           (row_v[3]),
      .col1           (col_v[0]),
      .col2           (col_v[1]),
      .col3           (col_v[2]),
      .reset_password (reset_password),
      .password_led   (password_led),
      .state          (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every change seen on the outputs must match the next queued expectation.
   initial begin
      logic [8:0] prev;
      logic [8:0] cur;
      exp_t       e;
      prev = 9'h1FF;
      forever begin
         @(negedge clk);
         cur = {state, password_led};
         if (cur != prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_change: got state=%0d led=%b at cycle %0d, required no change",
                        state, password_led, cyc);
            end else begin
               e = exp_q.pop_front();
               if (cur == {e.st, e.led}) passes++;
               else $display("FAIL %s: got state=%0d led=%b, required state=%0d led=%b",
                             e.nm, state, password_led, e.st, e.led);
               if (e.at >= 0) begin
                  checks++;
                  if (cyc == e.at) passes++;
                  else $display("FAIL %s_cycle: got cycle %0d, required cycle %0d", e.nm, cyc, e.at);
               end
            end
         end
         prev = cur;
      end
   end

   task automatic push(input logic [2:0] s, input logic [5:0] l, input int at, input logic [63:0] nm);
      exp_t e;
      e.st  = s;
      e.led = l;
      e.at  = at;
      e.nm  = nm;
      exp_q.push_back(e);
   endtask

   task automatic set_pins(input logic [3:0] k);
      row_v = '0;
      col_v = '0;
      if (k >= 4'd1 && k <= 4'd9) begin
         row_v[(k - 4'd1) / 4'd3] = 1'b1;
         col_v[(k - 4'd1) % 4'd3] = 1'b1;
      end else if (k == 4'd0) begin
         row_v[3] = 1'b1; col_v[1] = 1'b1;
      end else if (k == 4'hA) begin
         row_v[3] = 1'b1; col_v[0] = 1'b1;
      end else if (k == 4'hB) begin
         row_v[3] = 1'b1; col_v[2] = 1'b1;
      end
   endtask

   // kind 0: no visible change; 1: one change 3 cycles on; 2: WRONG then LOCKED after 4 cycles.
   task automatic key(input logic [3:0] k, input int kind, input logic [2:0] s, input logic [5:0] l,
                      input logic [63:0] nm, input int hold = 4);
      @(negedge clk);
      set_pins(k);
      if (kind > 0) push(s, l, cyc + 3, nm);
      if (kind == 2) push(3'd1, 6'h00, cyc + 7, "wr2lock");
      repeat (hold) @(negedge clk);
      set_pins(4'hF);
      repeat (4) @(negedge clk);
   endtask

   task automatic enter_n(input logic [23:0] pw, input int n, input logic [2:0] s);
      logic [3:0] d;
      for (int i = 0; i < n; i++) begin
         d = pw[23 - 4*i -: 4];
         key(d, 1, s, 6'((1 << (i + 1)) - 1), "digit");
      end
   endtask

   task automatic rp_pulse(input logic [2:0] s, input logic [63:0] nm);
      @(negedge clk);
      reset_password = 1'b1;
      push(s, 6'h00, cyc + 3, nm);
      repeat (4) @(negedge clk);
      reset_password = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      initialize_n   = 1'b0;
      row_v          = '0;
      col_v          = '0;
      reset_password = 1'b0;
      push(3'd0, 6'h00, -1, "reset");
      repeat (3) @(negedge clk);
      initialize_n = 1'b1;
      repeat (2) @(negedge clk);

      key(4'hB, 1, 3'd1, 6'h00, "off2lk");
      enter_n(24'h123456, 6, 3'd1);
      key(4'hA, 1, 3'd2, 6'h00, "open");
      key(4'hA, 1, 3'd1, 6'h00, "relock");

      enter_n(24'h123457, 6, 3'd1);
      key(4'hA, 2, 3'd3, 6'h00, "wrong7");

      enter_n(24'h123456, 5, 3'd1);
      key(4'hA, 2, 3'd3, 6'h00, "short5");

      enter_n(24'h123456, 6, 3'd1);
      key(4'h7, 0, 3'd1, 6'h3F, "d7");
      key(4'h8, 0, 3'd1, 6'h3F, "d8");
      key(4'hA, 1, 3'd2, 6'h00, "eight");

      rp_pulse(3'd4, "set");
      enter_n(24'h987654, 6, 3'd4);
      key(4'hA, 1, 3'd1, 6'h00, "newpw");
      enter_n(24'h987654, 6, 3'd1);
      key(4'hA, 1, 3'd2, 6'h00, "newok");
      key(4'hA, 1, 3'd1, 6'h00, "relock2");
      enter_n(24'h123456, 6, 3'd1);
      key(4'hA, 2, 3'd3, 6'h00, "oldpw");

      key(4'h5, 1, 3'd1, 6'h01, "hold5", 20);
      @(negedge clk);
      row_v = 4'b0011;
      col_v = 3'b001;
      repeat (6) @(negedge clk);
      set_pins(4'hF);
      repeat (4) @(negedge clk);
      key(4'h5, 1, 3'd1, 6'h03, "second5");
      key(4'hB, 1, 3'd0, 6'h00, "sharp");

      key(4'hB, 1, 3'd1, 6'h00, "on");
      enter_n(24'h987654, 6, 3'd1);
      key(4'hA, 1, 3'd2, 6'h00, "open3");
      rp_pulse(3'd4, "set2");
      enter_n(24'h120000, 2, 3'd4);
      key(4'hA, 1, 3'd2, 6'h00, "setshort");
      rp_pulse(3'd4, "set3");
      enter_n(24'h110000, 2, 3'd4);

      @(negedge clk);
      push(3'd0, 6'h00, -1, "arst");
      initialize_n = 1'b0;
      repeat (2) @(negedge clk);
      initialize_n = 1'b1;
      repeat (4) @(negedge clk);
      key(4'hB, 1, 3'd1, 6'h00, "on2");
      enter_n(24'h123456, 6, 3'd1);
      key(4'hA, 1, 3'd2, 6'h00, "defpw");

      repeat (10) @(negedge clk);
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
